// File: rtl/cache_mem_arbiter.sv
// Shares one memory read channel (round-robin, grant held for the whole burst) and one
// write channel (D-cache pass-through) between the I-cache and D-cache. Blocks I-cache reads that hit an in-flight write-back line.
module cache_mem_arbiter #(
  parameter int LINE_OFFSET_BITS = 5
) (
  input  logic        clk,
  input  logic        rst,
  // I-cache read port
  input  logic        from_ic_rd_req_valid,
  input  logic [31:0] from_ic_rd_req_addr,
  input  logic [7:0]  from_ic_rd_req_len,
  output logic        to_ic_rd_req_ready,
  output logic        to_ic_rd_rsp_valid,
  output logic [31:0] to_ic_rd_rsp_data,
  output logic        to_ic_rd_rsp_last,
  input  logic        from_ic_rd_rsp_ready,
  // D-cache read port
  input  logic        from_dc_rd_req_valid,
  input  logic [31:0] from_dc_rd_req_addr,
  input  logic [7:0]  from_dc_rd_req_len,
  output logic        to_dc_rd_req_ready,
  output logic        to_dc_rd_rsp_valid,
  output logic [31:0] to_dc_rd_rsp_data,
  output logic        to_dc_rd_rsp_last,
  input  logic        from_dc_rd_rsp_ready,
  // D-cache write port
  input  logic        from_dc_wr_req_valid,
  input  logic [31:0] from_dc_wr_req_addr,
  input  logic [7:0]  from_dc_wr_req_len,
  output logic        to_dc_wr_req_ready,
  input  logic        from_dc_wr_data_valid,
  input  logic [31:0] from_dc_wr_data,
  input  logic [3:0]  from_dc_wr_data_strb,
  input  logic        from_dc_wr_data_last,
  output logic        to_dc_wr_data_ready,
  // memory read channel
  output logic        to_mem_rd_req_valid,
  output logic [31:0] to_mem_rd_req_addr,
  output logic [7:0]  to_mem_rd_req_len,
  input  logic        from_mem_rd_req_ready,
  input  logic        from_mem_rd_rsp_valid,
  input  logic [31:0] from_mem_rd_rsp_data,
  input  logic        from_mem_rd_rsp_last,
  output logic        to_mem_rd_rsp_ready,
  // memory write channel
  output logic        to_mem_wr_req_valid,
  output logic [31:0] to_mem_wr_req_addr,
  output logic [7:0]  to_mem_wr_req_len,
  input  logic        from_mem_wr_req_ready,
  output logic        to_mem_wr_data_valid,
  output logic [31:0] to_mem_wr_data,
  output logic [3:0]  to_mem_wr_data_strb,
  output logic        to_mem_wr_data_last,
  input  logic        from_mem_wr_data_ready,
  // state visibility
  output logic [2:0]  dbg_rd_state,
  output logic        dbg_wr_state
);
  // Handshake rule on every channel: a transfer happens on a rising edge where valid and
  // ready are both 1; valid, once raised, holds its payload stable until that edge.

  localparam int LW = 32 - LINE_OFFSET_BITS;

  typedef enum logic [2:0] {R_IDLE = 3'b001, R_REQ = 3'b010, R_RSP = 3'b100} rd_state_t;
  typedef enum logic {W_IDLE = 1'b0, W_DATA = 1'b1} wr_state_t;

  rd_state_t       rd_state, rd_next;
  wr_state_t       wr_state, wr_next;
  logic            grant, grant_next;        // 0 = I-cache, 1 = D-cache
  logic            last_grant, last_grant_next;
  logic [LW-1:0]   wr_line;
  logic            hazard, ic_elig, dc_elig;
  logic            sel_req_valid, sel_rsp_ready;

  // An I-cache read must not overtake a write-back to the same line.
  assign hazard = ((wr_state == W_DATA) && (from_ic_rd_req_addr[31:LINE_OFFSET_BITS] == wr_line)) ||
                  ((wr_state == W_IDLE) && from_dc_wr_req_valid &&
                   (from_ic_rd_req_addr[31:LINE_OFFSET_BITS] == from_dc_wr_req_addr[31:LINE_OFFSET_BITS]));
  assign ic_elig = from_ic_rd_req_valid && !hazard;
  assign dc_elig = from_dc_rd_req_valid;

  assign dbg_rd_state = rd_state;
  assign dbg_wr_state = wr_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_state   <= R_IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      rd_state   <= rd_next;
      grant      <= grant_next;
      last_grant <= last_grant_next;
    end
  end

  always_comb begin
    rd_next             = rd_state;
    grant_next          = grant;
    last_grant_next     = last_grant;
    to_mem_rd_req_valid = 1'b0;
    to_mem_rd_req_addr  = '0;
    to_mem_rd_req_len   = '0;
    to_mem_rd_rsp_ready = 1'b0;
    to_ic_rd_req_ready  = 1'b0;
    to_dc_rd_req_ready  = 1'b0;
    to_ic_rd_rsp_valid  = 1'b0;
    to_ic_rd_rsp_data   = '0;
    to_ic_rd_rsp_last   = 1'b0;
    to_dc_rd_rsp_valid  = 1'b0;
    to_dc_rd_rsp_data   = '0;
    to_dc_rd_rsp_last   = 1'b0;
    sel_req_valid       = grant ? from_dc_rd_req_valid : from_ic_rd_req_valid;
    sel_rsp_ready       = grant ? from_dc_rd_rsp_ready : from_ic_rd_rsp_ready;
    unique case (rd_state)
      R_IDLE: begin
        if (dc_elig && ic_elig) begin
          grant_next = ~last_grant;
          rd_next    = R_REQ;
        end else if (dc_elig) begin
          grant_next = 1'b1;
          rd_next    = R_REQ;
        end else if (ic_elig) begin
          grant_next = 1'b0;
          rd_next    = R_REQ;
        end
      end
      R_REQ: begin
        to_mem_rd_req_valid = sel_req_valid;
        to_mem_rd_req_addr  = grant ? from_dc_rd_req_addr : from_ic_rd_req_addr;
        to_mem_rd_req_len   = grant ? from_dc_rd_req_len : from_ic_rd_req_len;
        if (grant) to_dc_rd_req_ready = from_mem_rd_req_ready;
        else       to_ic_rd_req_ready = from_mem_rd_req_ready;
        // A master withdrawing its request abandons the grant.
        if (!sel_req_valid)             rd_next = R_IDLE;
        else if (from_mem_rd_req_ready) rd_next = R_RSP;
      end
      R_RSP: begin
        to_mem_rd_rsp_ready = sel_rsp_ready;
        if (grant) begin
          to_dc_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_dc_rd_rsp_data  = from_mem_rd_rsp_data;
          to_dc_rd_rsp_last  = from_mem_rd_rsp_last;
        end else begin
          to_ic_rd_rsp_valid = from_mem_rd_rsp_valid;
          to_ic_rd_rsp_data  = from_mem_rd_rsp_data;
          to_ic_rd_rsp_last  = from_mem_rd_rsp_last;
        end
        if (from_mem_rd_rsp_valid && sel_rsp_ready && from_mem_rd_rsp_last) begin
          rd_next         = R_IDLE;
          last_grant_next = grant;
        end
      end
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= W_IDLE;
      wr_line  <= '0;
    end else begin
      wr_state <= wr_next;
      if (wr_state == W_IDLE && from_dc_wr_req_valid && from_mem_wr_req_ready)
        wr_line <= from_dc_wr_req_addr[31:LINE_OFFSET_BITS];
    end
  end

  always_comb begin
    wr_next              = wr_state;
    to_mem_wr_req_valid  = 1'b0;
    to_dc_wr_req_ready   = 1'b0;
    to_mem_wr_data_valid = 1'b0;
    to_dc_wr_data_ready  = 1'b0;
    to_mem_wr_req_addr   = from_dc_wr_req_addr;
    to_mem_wr_req_len    = from_dc_wr_req_len;
    to_mem_wr_data       = from_dc_wr_data;
    to_mem_wr_data_strb  = from_dc_wr_data_strb;
    to_mem_wr_data_last  = from_dc_wr_data_last;
    unique case (wr_state)
      W_IDLE: begin
        to_mem_wr_req_valid = from_dc_wr_req_valid;
        to_dc_wr_req_ready  = from_mem_wr_req_ready;
        if (from_dc_wr_req_valid && from_mem_wr_req_ready) wr_next = W_DATA;
      end
      W_DATA: begin
        to_mem_wr_data_valid = from_dc_wr_data_valid;
        to_dc_wr_data_ready  = from_mem_wr_data_ready;
        if (from_dc_wr_data_valid && from_mem_wr_data_ready && from_dc_wr_data_last)
          wr_next = W_IDLE;
      end
      default: wr_next = W_IDLE;
    endcase
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed bench for cache_mem_arbiter: one task per scenario, each with hand-computed
// expectations checked inline.
module tb_cache_mem_arbiter;
  logic        clk, rst;
  logic        from_ic_rd_req_valid, from_ic_rd_rsp_ready;
  logic [31:0] from_ic_rd_req_addr;
  logic [7:0]  from_ic_rd_req_len;
  logic        to_ic_rd_req_ready, to_ic_rd_rsp_valid, to_ic_rd_rsp_last;
  logic [31:0] to_ic_rd_rsp_data;
  logic        from_dc_rd_req_valid, from_dc_rd_rsp_ready;
  logic [31:0] from_dc_rd_req_addr;
  logic [7:0]  from_dc_rd_req_len;
  logic        to_dc_rd_req_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_last;
  logic [31:0] to_dc_rd_rsp_data;
  logic        from_dc_wr_req_valid, to_dc_wr_req_ready;
  logic [31:0] from_dc_wr_req_addr;
  logic [7:0]  from_dc_wr_req_len;
  logic        from_dc_wr_data_valid, from_dc_wr_data_last, to_dc_wr_data_ready;
  logic [31:0] from_dc_wr_data;
  logic [3:0]  from_dc_wr_data_strb;
  logic        to_mem_rd_req_valid, from_mem_rd_req_ready;
  logic [31:0] to_mem_rd_req_addr;
  logic [7:0]  to_mem_rd_req_len;
  logic        from_mem_rd_rsp_valid, from_mem_rd_rsp_last, to_mem_rd_rsp_ready;
  logic [31:0] from_mem_rd_rsp_data;
  logic        to_mem_wr_req_valid, from_mem_wr_req_ready;
  logic [31:0] to_mem_wr_req_addr;
  logic [7:0]  to_mem_wr_req_len;
  logic        to_mem_wr_data_valid, to_mem_wr_data_last, from_mem_wr_data_ready;
  logic [31:0] to_mem_wr_data;
  logic [3:0]  to_mem_wr_data_strb;
  logic [2:0]  dbg_rd_state;
  logic        dbg_wr_state;

  int checks = 0;
  int failures = 0;

  cache_mem_arbiter #(.LINE_OFFSET_BITS(5)) dut (
    .clk(clk), .rst(rst),
    .from_ic_rd_req_valid(from_ic_rd_req_valid), .from_ic_rd_req_addr(from_ic_rd_req_addr),
    .from_ic_rd_req_len(from_ic_rd_req_len), .to_ic_rd_req_ready(to_ic_rd_req_ready),
    .to_ic_rd_rsp_valid(to_ic_rd_rsp_valid), .to_ic_rd_rsp_data(to_ic_rd_rsp_data),
    .to_ic_rd_rsp_last(to_ic_rd_rsp_last), .from_ic_rd_rsp_ready(from_ic_rd_rsp_ready),
    .from_dc_rd_req_valid(from_dc_rd_req_valid), .from_dc_rd_req_addr(from_dc_rd_req_addr),
    .from_dc_rd_req_len(from_dc_rd_req_len), .to_dc_rd_req_ready(to_dc_rd_req_ready),
    .to_dc_rd_rsp_valid(to_dc_rd_rsp_valid), .to_dc_rd_rsp_data(to_dc_rd_rsp_data),
    .to_dc_rd_rsp_last(to_dc_rd_rsp_last), .from_dc_rd_rsp_ready(from_dc_rd_rsp_ready),
    .from_dc_wr_req_valid(from_dc_wr_req_valid), .from_dc_wr_req_addr(from_dc_wr_req_addr),
    .from_dc_wr_req_len(from_dc_wr_req_len), .to_dc_wr_req_ready(to_dc_wr_req_ready),
    .from_dc_wr_data_valid(from_dc_wr_data_valid), .from_dc_wr_data(from_dc_wr_data),
    .from_dc_wr_data_strb(from_dc_wr_data_strb), .from_dc_wr_data_last(from_dc_wr_data_last),
    .to_dc_wr_data_ready(to_dc_wr_data_ready),
    .to_mem_rd_req_valid(to_mem_rd_req_valid), .to_mem_rd_req_addr(to_mem_rd_req_addr),
    .to_mem_rd_req_len(to_mem_rd_req_len), .from_mem_rd_req_ready(from_mem_rd_req_ready),
    .from_mem_rd_rsp_valid(from_mem_rd_rsp_valid), .from_mem_rd_rsp_data(from_mem_rd_rsp_data),
    .from_mem_rd_rsp_last(from_mem_rd_rsp_last), .to_mem_rd_rsp_ready(to_mem_rd_rsp_ready),
    .to_mem_wr_req_valid(to_mem_wr_req_valid), .to_mem_wr_req_addr(to_mem_wr_req_addr),
    .to_mem_wr_req_len(to_mem_wr_req_len), .from_mem_wr_req_ready(from_mem_wr_req_ready),
    .to_mem_wr_data_valid(to_mem_wr_data_valid), .to_mem_wr_data(to_mem_wr_data),
    .to_mem_wr_data_strb(to_mem_wr_data_strb), .to_mem_wr_data_last(to_mem_wr_data_last),
    .from_mem_wr_data_ready(from_mem_wr_data_ready),
    .dbg_rd_state(dbg_rd_state), .dbg_wr_state(dbg_wr_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    from_ic_rd_req_valid = 0; from_ic_rd_req_addr = 0; from_ic_rd_req_len = 0; from_ic_rd_rsp_ready = 0;
    from_dc_rd_req_valid = 0; from_dc_rd_req_addr = 0; from_dc_rd_req_len = 0; from_dc_rd_rsp_ready = 0;
    from_dc_wr_req_valid = 0; from_dc_wr_req_addr = 0; from_dc_wr_req_len = 0;
    from_dc_wr_data_valid = 0; from_dc_wr_data = 0; from_dc_wr_data_strb = 0; from_dc_wr_data_last = 0;
    from_mem_rd_req_ready = 0; from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_data = 0; from_mem_rd_rsp_last = 0;
    from_mem_wr_req_ready = 0; from_mem_wr_data_ready = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // memory-side drivers
  task automatic mem_accept_req(output logic [31:0] addr, output logic [7:0] len, output bit ok);
    ok = 0; addr = '0; len = '0;
    for (int k = 0; k < 20 && !ok; k++) begin
      #1;
      if (to_mem_rd_req_valid === 1'b1) begin
        addr = to_mem_rd_req_addr;
        len  = to_mem_rd_req_len;
        ok   = 1;
        from_mem_rd_req_ready = 1'b1;
      end
      step();
      from_mem_rd_req_ready = 1'b0;
    end
  endtask

  task automatic mem_send_beats(input int n, input logic [31:0] base, output bit ok);
    int k;
    ok = 1;
    for (int i = 0; i < n; i++) begin
      from_mem_rd_rsp_valid = 1'b1;
      from_mem_rd_rsp_data  = base + 32'(i);
      from_mem_rd_rsp_last  = (i == n - 1);
      #1;
      k = 0;
      while (to_mem_rd_rsp_ready !== 1'b1 && k < 50) begin
        step(); k++;
      end
      if (k >= 50) ok = 0;
      step();
    end
    from_mem_rd_rsp_valid = 1'b0;
    from_mem_rd_rsp_last  = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    from_mem_rd_req_ready = 1; from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_last = 1;
    from_mem_rd_rsp_data = 32'hFFFF; from_ic_rd_rsp_ready = 1; from_dc_rd_rsp_ready = 1;
    from_dc_wr_data_valid = 1; from_mem_wr_data_ready = 1; from_dc_wr_req_valid = 1;
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if ({to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_req_ready, to_dc_rd_req_ready} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_rd_ctrl: got %b expected 0000", {to_mem_rd_req_valid, to_mem_rd_rsp_ready, to_ic_rd_req_ready, to_dc_rd_req_ready});
    end
    checks++;
    if ({to_ic_rd_rsp_valid, to_ic_rd_rsp_last, to_dc_rd_rsp_valid, to_dc_rd_rsp_last} !== 4'b0000 ||
        to_ic_rd_rsp_data !== 32'h0 || to_dc_rd_rsp_data !== 32'h0) begin
      failures++;
      $display("FAIL reset_rsp: ic_data=%h dc_data=%h expected 0", to_ic_rd_rsp_data, to_dc_rd_rsp_data);
    end
    checks++;
    if ({to_mem_wr_data_valid, to_dc_wr_data_ready, to_mem_wr_req_valid} !== 3'b001) begin
      failures++;
      $display("FAIL reset_wr: {data_valid,data_ready,req_valid}=%b expected 001", {to_mem_wr_data_valid, to_dc_wr_data_ready, to_mem_wr_req_valid});
    end
    checks++;
    if (dbg_rd_state !== 3'b001 || dbg_wr_state !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: rd=%b wr=%b expected 001/0", dbg_rd_state, dbg_wr_state);
    end
    clear_inputs();
    #1;
    checks++;
    if (to_mem_wr_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_wr_req_follow: got %b expected 0", to_mem_wr_req_valid);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_ic_read();
    logic [31:0] exp_d;
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h0000_1020; from_ic_rd_req_len = 8'd7;
    from_ic_rd_rsp_ready = 1;
    #1;
    checks++;
    if (to_mem_rd_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL ic_read_arb_cycle: mem req valid=%b expected 0", to_mem_rd_req_valid);
    end
    step();
    #1;
    checks++;
    if (to_mem_rd_req_valid !== 1'b1 || to_mem_rd_req_addr !== 32'h0000_1020 || to_mem_rd_req_len !== 8'd7) begin
      failures++;
      $display("FAIL ic_read_req: valid=%b addr=%h len=%0d expected 1/00001020/7", to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_rd_req_len);
    end
    from_mem_rd_req_ready = 1;
    #1;
    checks++;
    if (to_ic_rd_req_ready !== 1'b1 || to_dc_rd_req_ready !== 1'b0) begin
      failures++;
      $display("FAIL ic_read_ready: ic=%b dc=%b expected 1/0", to_ic_rd_req_ready, to_dc_rd_req_ready);
    end
    step();
    from_ic_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    for (int i = 0; i < 8; i++) begin
      exp_d = 32'hA0 + 32'(i);
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = exp_d; from_mem_rd_rsp_last = (i == 7);
      #1;
      checks++;
      if ({to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last} !== {1'b1, exp_d, (i == 7)}) begin
        failures++;
        $display("FAIL ic_read_beat%0d: valid=%b data=%h last=%b expected 1/%h/%b", i, to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last, exp_d, (i == 7));
      end
      checks++;
      if (to_dc_rd_rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL ic_read_dc_quiet%0d: dc valid=%b expected 0", i, to_dc_rd_rsp_valid);
      end
      step();
    end
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0;
    #1;
    checks++;
    if (dbg_rd_state !== 3'b001) begin
      failures++;
      $display("FAIL ic_read_done: rd state=%b expected 001", dbg_rd_state);
    end
    clear_inputs();
  endtask

  task automatic test_arbitration();
    logic [31:0] a, exp_a[3];
    logic [7:0]  l;
    bit ok, bok;
    exp_a[0] = 32'h100; exp_a[1] = 32'h200; exp_a[2] = 32'h100;
    do_reset();
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h100; from_ic_rd_req_len = 8'd1;
    from_dc_rd_req_valid = 1; from_dc_rd_req_addr = 32'h200; from_dc_rd_req_len = 8'd1;
    from_ic_rd_rsp_ready = 1; from_dc_rd_rsp_ready = 1;
    for (int r = 0; r < 3; r++) begin
      mem_accept_req(a, l, ok);
      checks++;
      if (!ok || a !== exp_a[r]) begin
        failures++;
        $display("FAIL arb_round%0d: ok=%0d addr=%h expected %h", r, ok, a, exp_a[r]);
      end
      if (r == 2) begin
        from_ic_rd_req_valid = 0; from_dc_rd_req_valid = 0;
      end
      mem_send_beats(2, 32'h10 * 32'(r), bok);
      checks++;
      if (!bok) begin
        failures++;
        $display("FAIL arb_beats%0d: beat handshake timed out, expected completion", r);
      end
    end
    clear_inputs();
  endtask

  task automatic test_dc_rsp_toggle();
    logic [31:0] a;
    logic [7:0]  l;
    bit ok, bok, tog;
    int got;
    from_dc_rd_req_valid = 1; from_dc_rd_req_addr = 32'h400; from_dc_rd_req_len = 8'd3;
    mem_accept_req(a, l, ok);
    checks++;
    if (!ok || a !== 32'h400 || l !== 8'd3) begin
      failures++;
      $display("FAIL toggle_dc_req: ok=%0d addr=%h len=%0d expected 00000400/3", ok, a, l);
    end
    from_dc_rd_req_valid = 0;
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h500; from_ic_rd_req_len = 8'd0;
    from_ic_rd_rsp_ready = 1;
    from_mem_rd_rsp_valid = 1;
    got = 0;
    for (int c = 0; c < 20 && got < 4; c++) begin
      tog = (c % 2 == 0);
      from_dc_rd_rsp_ready = tog;
      from_mem_rd_rsp_data = 32'hD0 + 32'(got);
      from_mem_rd_rsp_last = (got == 3);
      #1;
      checks++;
      if (to_mem_rd_rsp_ready !== tog || to_dc_rd_rsp_valid !== 1'b1 || to_dc_rd_rsp_data !== 32'hD0 + 32'(got)) begin
        failures++;
        $display("FAIL toggle_beat_c%0d: mem_ready=%b dc_valid=%b data=%h expected %b/1/%h", c, to_mem_rd_rsp_ready, to_dc_rd_rsp_valid, to_dc_rd_rsp_data, tog, 32'hD0 + 32'(got));
      end
      checks++;
      if (to_mem_rd_req_valid !== 1'b0 || to_ic_rd_rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL toggle_ic_wait_c%0d: req_valid=%b ic_rsp_valid=%b expected 0/0", c, to_mem_rd_req_valid, to_ic_rd_rsp_valid);
      end
      step();
      if (tog) got++;
    end
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0; from_dc_rd_rsp_ready = 0;
    checks++;
    if (got !== 4) begin
      failures++;
      $display("FAIL toggle_count: beats=%0d expected 4", got);
    end
    mem_accept_req(a, l, ok);
    checks++;
    if (!ok || a !== 32'h500) begin
      failures++;
      $display("FAIL toggle_ic_after: ok=%0d addr=%h expected 00000500", ok, a);
    end
    from_ic_rd_req_valid = 0;
    mem_send_beats(1, 32'h55, bok);
    checks++;
    if (!bok) begin
      failures++;
      $display("FAIL toggle_ic_beat: handshake timed out, expected completion");
    end
    clear_inputs();
  endtask

  task automatic test_write_hazard();
    int beat, ic_cyc, last_cyc;
    bit dc_seen, st3, st6, stall, dc_drop, ic_drop;
    logic [31:0] exp_d;
    from_dc_wr_req_valid = 1; from_dc_wr_req_addr = 32'h0000_2000; from_dc_wr_req_len = 8'd7;
    from_mem_wr_req_ready = 1;
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h0000_2010; from_ic_rd_req_len = 8'd0;
    from_dc_rd_req_valid = 1; from_dc_rd_req_addr = 32'h600; from_dc_rd_req_len = 8'd0;
    from_mem_rd_req_ready = 1; from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'hBB;
    from_mem_rd_rsp_last = 1; from_ic_rd_rsp_ready = 1; from_dc_rd_rsp_ready = 1;
    #1;
    checks++;
    if ({to_mem_wr_req_valid, to_dc_wr_req_ready, to_mem_wr_data_valid} !== 3'b110) begin
      failures++;
      $display("FAIL hz_wr_req: {req_valid,req_ready,data_valid}=%b expected 110", {to_mem_wr_req_valid, to_dc_wr_req_ready, to_mem_wr_data_valid});
    end
    step();
    from_dc_wr_req_valid = 0; from_mem_wr_req_ready = 0;
    beat = 0; ic_cyc = -1; last_cyc = -1; dc_seen = 0; st3 = 0; st6 = 0;
    for (int c = 0; c < 30 && ic_cyc < 0; c++) begin
      stall = 0;
      exp_d = 32'h5000 + 32'(beat);
      if (beat < 8) begin
        stall = (beat == 3 && !st3) || (beat == 6 && !st6);
        from_dc_wr_data_valid = 1; from_dc_wr_data = exp_d;
        from_dc_wr_data_strb = 4'hF ^ 4'(beat); from_dc_wr_data_last = (beat == 7);
        from_mem_wr_data_ready = !stall;
      end else begin
        from_dc_wr_data_valid = 0; from_dc_wr_data_last = 0; from_mem_wr_data_ready = 0;
      end
      #1;
      if (beat < 8) begin
        checks++;
        if (to_mem_wr_data_valid !== 1'b1 || to_mem_wr_data !== exp_d || to_mem_wr_data_strb !== (4'hF ^ 4'(beat)) ||
            to_mem_wr_data_last !== (beat == 7) || to_dc_wr_data_ready !== !stall || to_mem_wr_req_valid !== 1'b0) begin
          failures++;
          $display("FAIL hz_wr_beat_c%0d: valid=%b data=%h ready=%b expected 1/%h/%b", c, to_mem_wr_data_valid, to_mem_wr_data, to_dc_wr_data_ready, exp_d, !stall);
        end
      end
      if (to_mem_rd_req_valid === 1'b1 && to_mem_rd_req_addr === 32'h600) dc_seen = 1;
      if (to_mem_rd_req_valid === 1'b1 && to_mem_rd_req_addr === 32'h2010) ic_cyc = c;
      dc_drop = to_dc_rd_req_ready;
      ic_drop = to_ic_rd_req_ready;
      step();
      if (dc_drop) from_dc_rd_req_valid = 0;
      if (ic_drop) from_ic_rd_req_valid = 0;
      if (beat < 8) begin
        if (stall) begin
          if (beat == 3) st3 = 1; else st6 = 1;
        end else begin
          if (beat == 7) last_cyc = c;
          beat++;
        end
      end
    end
    checks++;
    if (dc_seen !== 1'b1) begin
      failures++;
      $display("FAIL hz_dc_grantable: dc read seen=%0d expected 1", dc_seen);
    end
    checks++;
    if (last_cyc !== 9) begin
      failures++;
      $display("FAIL hz_wr_last_cycle: got %0d expected 9", last_cyc);
    end
    checks++;
    if (ic_cyc !== 11) begin
      failures++;
      $display("FAIL hz_ic_release: ic req cycle=%0d expected 11", ic_cyc);
    end
    from_ic_rd_req_valid = 0;
    step();
    clear_inputs();
  endtask

  task automatic test_no_hazard_overlap();
    from_dc_wr_req_valid = 1; from_dc_wr_req_addr = 32'h0000_2000; from_dc_wr_req_len = 8'd3;
    from_mem_wr_req_ready = 1;
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h0000_3000; from_ic_rd_req_len = 8'd0;
    #1;
    checks++;
    if (to_dc_wr_req_ready !== 1'b1 || to_mem_wr_req_addr !== 32'h0000_2000 || to_mem_wr_req_len !== 8'd3) begin
      failures++;
      $display("FAIL nohz_wr_req: ready=%b addr=%h len=%0d expected 1/00002000/3", to_dc_wr_req_ready, to_mem_wr_req_addr, to_mem_wr_req_len);
    end
    step();
    from_dc_wr_req_valid = 0; from_mem_wr_req_ready = 0;
    from_dc_wr_data_valid = 1; from_dc_wr_data = 32'h6000; from_dc_wr_data_last = 0;
    from_mem_wr_data_ready = 1; from_mem_rd_req_ready = 1;
    #1;
    checks++;
    if (to_mem_rd_req_valid !== 1'b1 || to_mem_rd_req_addr !== 32'h0000_3000 || to_mem_wr_data_valid !== 1'b1) begin
      failures++;
      $display("FAIL nohz_overlap: rd_valid=%b rd_addr=%h wr_data_valid=%b expected 1/00003000/1", to_mem_rd_req_valid, to_mem_rd_req_addr, to_mem_wr_data_valid);
    end
    step();
    from_ic_rd_req_valid = 0; from_mem_rd_req_ready = 0;
    from_dc_wr_data = 32'h6001;
    from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'hC1; from_mem_rd_rsp_last = 1;
    from_ic_rd_rsp_ready = 1;
    #1;
    checks++;
    if ({to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_ic_rd_rsp_last} !== {1'b1, 32'hC1, 1'b1} ||
        to_mem_wr_data_valid !== 1'b1 || to_mem_wr_data !== 32'h6001) begin
      failures++;
      $display("FAIL nohz_rsp_during_wr: ic valid=%b data=%h wr data=%h expected 1/000000c1/00006001", to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_mem_wr_data);
    end
    step();
    from_mem_rd_rsp_valid = 0; from_mem_rd_rsp_last = 0;
    for (int i = 2; i < 4; i++) begin
      from_dc_wr_data = 32'h6000 + 32'(i); from_dc_wr_data_last = (i == 3);
      step();
    end
    clear_inputs();
    #1;
    checks++;
    if (dbg_rd_state !== 3'b001 || dbg_wr_state !== 1'b0) begin
      failures++;
      $display("FAIL nohz_idle: rd=%b wr=%b expected 001/0", dbg_rd_state, dbg_wr_state);
    end
  endtask

  task automatic test_reset_mid_burst();
    logic [31:0] a;
    logic [7:0]  l;
    bit ok, bok;
    from_ic_rd_req_valid = 1; from_ic_rd_req_addr = 32'h4000; from_ic_rd_req_len = 8'd7;
    from_ic_rd_rsp_ready = 1;
    mem_accept_req(a, l, ok);
    from_ic_rd_req_valid = 0;
    for (int i = 0; i < 4; i++) begin
      from_mem_rd_rsp_valid = 1; from_mem_rd_rsp_data = 32'hE0 + 32'(i); from_mem_rd_rsp_last = 0;
      step();
    end
    from_mem_rd_rsp_data = 32'hE4;
    #1;
    checks++;
    if (!ok || to_ic_rd_rsp_valid !== 1'b1 || to_ic_rd_rsp_data !== 32'hE4) begin
      failures++;
      $display("FAIL rstmid_beat4: ok=%0d valid=%b data=%h expected 1/000000e4", ok, to_ic_rd_rsp_valid, to_ic_rd_rsp_data);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (to_ic_rd_rsp_valid !== 1'b0 || to_ic_rd_rsp_data !== 32'h0 || to_mem_rd_rsp_ready !== 1'b0 || dbg_rd_state !== 3'b001) begin
      failures++;
      $display("FAIL rstmid_async: valid=%b data=%h mem_ready=%b state=%b expected 0/0/0/001", to_ic_rd_rsp_valid, to_ic_rd_rsp_data, to_mem_rd_rsp_ready, dbg_rd_state);
    end
    clear_inputs();
    @(posedge clk); #1 rst = 1'b1;
    from_dc_rd_req_valid = 1; from_dc_rd_req_addr = 32'h700; from_dc_rd_req_len = 8'd0;
    from_dc_rd_rsp_ready = 1;
    mem_accept_req(a, l, ok);
    checks++;
    if (!ok || a !== 32'h700) begin
      failures++;
      $display("FAIL rstmid_fresh_req: ok=%0d addr=%h expected 00000700", ok, a);
    end
    from_dc_rd_req_valid = 0;
    mem_send_beats(1, 32'h77, bok);
    #1;
    checks++;
    if (!bok || dbg_rd_state !== 3'b001) begin
      failures++;
      $display("FAIL rstmid_fresh_done: ok=%0d state=%b expected 1/001", bok, dbg_rd_state);
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b0;
    clear_inputs();
    test_reset();
    test_ic_read();
    test_arbitration();
    test_dc_rsp_toggle();
    test_write_hazard();
    test_no_hazard_overlap();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
